// File: rtl/signed_max_scanner.sv
// -----------------------------------------------------------------------------
// signed_max_scanner
// Streams a block of Length words from the source-memory read port and reports
// the largest word seen and its 0-based index. The compare is two's-complement
// when SIGNED=1 and unsigned when SIGNED=0. sign_o flags a replace event, which
// happens when the latest accepted word is strictly larger than the previous
// maximum.
//
// Optional build macro: SCANNER_MIN_TRACK_EN adds min_out_o/min_idx_o. These
// track the strict minimum under the same rules as the maximum.
//
// Ports:
//   clock_i     rising-edge clock
//   resetn_i    asynchronous active-low reset
//   start_i     begin scan (sampled only in IDLE)
//   length_i    words to scan (sampled with start_i)
//   din_i       data word; dvalid_i qualifies it
//   dready_o    word accepted this cycle when dvalid_i is high (SCAN)
//   busy_o      high in SCAN
//   done_o      one-cycle completion pulse
//   max_out_o   running maximum
//   max_idx_o   index of max_out_o
//   sign_o      last accepted word replaced the maximum
//   min_out_o   running minimum       (SCANNER_MIN_TRACK_EN only)
//   min_idx_o   index of min_out_o    (SCANNER_MIN_TRACK_EN only)
// -----------------------------------------------------------------------------
module signed_max_scanner #(
    parameter int WIDTH  = 8,
    parameter int LEN_W  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clock_i,
    input  logic             resetn_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] length_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             dvalid_i,
    output logic             dready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] max_out_o,
    output logic [LEN_W-1:0] max_idx_o,
    output logic             sign_o
`ifdef SCANNER_MIN_TRACK_EN
    ,
    output logic [WIDTH-1:0] min_out_o,
    output logic [LEN_W-1:0] min_idx_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] max_q,   max_d;
    logic [LEN_W-1:0] idx_q,   idx_d;
    logic             sign_q,  sign_d;
    logic [LEN_W-1:0] cnt_inc_s;
`ifdef SCANNER_MIN_TRACK_EN
    logic [WIDTH-1:0] min_q,   min_d;
    logic [LEN_W-1:0] midx_q,  midx_d;
`endif

    // Strict a > b, with the interpretation fixed by SIGNED.
    function automatic logic is_greater(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
        logic res;
        if (SIGNED) begin
            res = ($signed(a) > $signed(b));
        end else begin
            res = (a > b);
        end
        return res;
    endfunction

    // Length never exceeds 2^LEN_W-1, so the incremented count cannot wrap.
    assign cnt_inc_s = count_q + LEN_W'(1);

    // Next-state, counter and result update logic.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        max_d   = max_q;
        idx_d   = idx_q;
        sign_d  = sign_q;
`ifdef SCANNER_MIN_TRACK_EN
        min_d   = min_q;
        midx_d  = midx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (length_i == {LEN_W{1'b0}}) begin
                        // An empty block completes at once with a zeroed result.
                        state_d = ST_DONE;
                        max_d   = {WIDTH{1'b0}};
                        idx_d   = {LEN_W{1'b0}};
                        sign_d  = 1'b0;
`ifdef SCANNER_MIN_TRACK_EN
                        min_d   = {WIDTH{1'b0}};
                        midx_d  = {LEN_W{1'b0}};
`endif
                    end else begin
                        state_d = ST_SCAN;
                        len_d   = length_i;
                        count_d = {LEN_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (dvalid_i) begin
                    count_d = cnt_inc_s;
                    if (count_q == {LEN_W{1'b0}}) begin
                        // The first word seeds the result unconditionally.
                        max_d  = din_i;
                        idx_d  = {LEN_W{1'b0}};
                        sign_d = 1'b0;
`ifdef SCANNER_MIN_TRACK_EN
                        min_d  = din_i;
                        midx_d = {LEN_W{1'b0}};
`endif
                    end else begin
                        // A strict compare keeps the earlier index on ties.
                        if (is_greater(din_i, max_q)) begin
                            max_d  = din_i;
                            idx_d  = count_q;
                            sign_d = 1'b1;
                        end else begin
                            sign_d = 1'b0;
                        end
`ifdef SCANNER_MIN_TRACK_EN
                        if (is_greater(min_q, din_i)) begin
                            min_d  = din_i;
                            midx_d = count_q;
                        end else begin
                            min_d  = min_q;
                        end
`endif
                    end
                    if (cnt_inc_s == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end else begin
                    // A stall leaves every register, including sign, unchanged.
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset clears everything, including mid-scan.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            len_q   <= {LEN_W{1'b0}};
            count_q <= {LEN_W{1'b0}};
            max_q   <= {WIDTH{1'b0}};
            idx_q   <= {LEN_W{1'b0}};
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            sign_q  <= sign_d;
        end
    end

`ifdef SCANNER_MIN_TRACK_EN
    // Minimum-tracking registers.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            min_q  <= {WIDTH{1'b0}};
            midx_q <= {LEN_W{1'b0}};
        end else begin
            min_q  <= min_d;
            midx_q <= midx_d;
        end
    end

    assign min_out_o = min_q;
    assign min_idx_o = midx_q;
`endif

    // The handshake and status outputs decode only the state register.
    assign dready_o  = (state_q == ST_SCAN);
    assign busy_o    = (state_q == ST_SCAN);
    assign done_o    = (state_q == ST_DONE);
    assign max_out_o = max_q;
    assign max_idx_o = idx_q;
    assign sign_o    = sign_q;

endmodule

// File: tb/tb_signed_max_scanner.sv
// -----------------------------------------------------------------------------
// tb_signed_max_scanner
// Drives a signed (index 0) and an unsigned (index 1) scanner with the same
// stimulus. Expected outputs come from a block-level model that keeps the list
// of accepted words and derives max/index/replace from that list on each
// accept. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_signed_max_scanner;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] length = 8'd0;
    logic [7:0] din = 8'd0;
    logic       dvalid = 1'b0;

    logic       dready_o [2];
    logic       busy_o   [2];
    logic       done_o   [2];
    logic [7:0] max_o    [2];
    logic [7:0] idx_o    [2];
    logic       sign_o   [2];
`ifdef SCANNER_MIN_TRACK_EN
    logic [7:0] min_o    [2];
    logic [7:0] midx_o   [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    signed_max_scanner #(.WIDTH(8), .LEN_W(8), .SIGNED(1'b1)) u_signed (
        .clock_i(clock), .resetn_i(resetn), .start_i(start), .length_i(length),
        .din_i(din), .dvalid_i(dvalid), .dready_o(dready_o[0]), .busy_o(busy_o[0]),
        .done_o(done_o[0]), .max_out_o(max_o[0]), .max_idx_o(idx_o[0]), .sign_o(sign_o[0])
`ifdef SCANNER_MIN_TRACK_EN
        , .min_out_o(min_o[0]), .min_idx_o(midx_o[0])
`endif
    );

    signed_max_scanner #(.WIDTH(8), .LEN_W(8), .SIGNED(1'b0)) u_unsigned (
        .clock_i(clock), .resetn_i(resetn), .start_i(start), .length_i(length),
        .din_i(din), .dvalid_i(dvalid), .dready_o(dready_o[1]), .busy_o(busy_o[1]),
        .done_o(done_o[1]), .max_out_o(max_o[1]), .max_idx_o(idx_o[1]), .sign_o(sign_o[1])
`ifdef SCANNER_MIN_TRACK_EN
        , .min_out_o(min_o[1]), .min_idx_o(midx_o[1])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_state = 0;          // 0 idle, 1 scanning, 2 done
    int         m_len   = 0;
    logic [7:0] m_w[$];
    logic [7:0] m_max  [2] = '{8'd0, 8'd0};
    logic [7:0] m_idx  [2] = '{8'd0, 8'd0};
    logic       m_sign [2] = '{1'b0, 1'b0};
    logic [7:0] m_min  [2] = '{8'd0, 8'd0};
    logic [7:0] m_midx [2] = '{8'd0, 8'd0};

    function automatic bit gt(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        return sgn ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    // Best of the first n accepted words; the first occurrence wins ties.
    function automatic logic [7:0] best_of(input int n, input bit sgn, input bit want_max,
                                           output int where);
        logic [7:0] b;
        b = m_w[0];
        where = 0;
        for (int i = 1; i < n; i++) begin
            if (want_max ? gt(m_w[i], b, sgn) : gt(b, m_w[i], sgn)) begin
                b = m_w[i];
                where = i;
            end
        end
        return b;
    endfunction

    always @(posedge clock or negedge resetn) begin
        int n, w;
        logic [7:0] prev;
        if (!resetn) begin
            m_state = 0;
            m_len = 0;
            m_w.delete();
            for (int k = 0; k < 2; k++) begin
                m_max[k] = 8'd0; m_idx[k] = 8'd0; m_sign[k] = 1'b0;
                m_min[k] = 8'd0; m_midx[k] = 8'd0;
            end
        end else begin
            case (m_state)
                0: if (start) begin
                    if (length == 8'd0) begin
                        m_state = 2;
                        for (int k = 0; k < 2; k++) begin
                            m_max[k] = 8'd0; m_idx[k] = 8'd0; m_sign[k] = 1'b0;
                            m_min[k] = 8'd0; m_midx[k] = 8'd0;
                        end
                    end else begin
                        m_state = 1;
                        m_len = int'(length);
                        m_w.delete();
                    end
                end
                1: if (dvalid) begin
                    m_w.push_back(din);
                    n = m_w.size();
                    for (int k = 0; k < 2; k++) begin
                        m_max[k] = best_of(n, k == 0, 1'b1, w);
                        m_idx[k] = 8'(w);
                        m_min[k] = best_of(n, k == 0, 1'b0, w);
                        m_midx[k] = 8'(w);
                        if (n == 1) begin
                            m_sign[k] = 1'b0;
                        end else begin
                            prev = best_of(n - 1, k == 0, 1'b1, w);
                            m_sign[k] = gt(din, prev, k == 0);
                        end
                    end
                    if (n == m_len) m_state = 2;
                end
                default: m_state = 0;
            endcase
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dready[%0d]", k), 32'(dready_o[k]), 32'(m_state == 1));
                chk($sformatf("busy[%0d]", k),   32'(busy_o[k]),   32'(m_state == 1));
                chk($sformatf("done[%0d]", k),   32'(done_o[k]),   32'(m_state == 2));
                chk($sformatf("max[%0d]", k),    32'(max_o[k]),    32'(m_max[k]));
                chk($sformatf("idx[%0d]", k),    32'(idx_o[k]),    32'(m_idx[k]));
                chk($sformatf("sign[%0d]", k),   32'(sign_o[k]),   32'(m_sign[k]));
`ifdef SCANNER_MIN_TRACK_EN
                chk($sformatf("min[%0d]", k),    32'(min_o[k]),    32'(m_min[k]));
                chk($sformatf("midx[%0d]", k),   32'(midx_o[k]),   32'(m_midx[k]));
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int guard = 0;
        while (m_state != 0 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        chk("wait_idle_timeout", 32'(m_state), 32'd0);
    endtask

    task automatic start_scan(input logic [7:0] len);
        wait_idle();
        start = 1'b1;
        length = len;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] w);
        din = w;
        dvalid = 1'b1;
        @(negedge clock);
        dvalid = 1'b0;
    endtask

    logic [7:0] seq4 [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    logic       sgn_s [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       sgn_u [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_max", 32'(max_o[0]), 32'h0);
        chk("rst_done", 32'(done_o[1]), 32'h0);
        resetn = 1'b1;
        @(negedge clock);

        // Signed vs unsigned on 00,7F,80,FF with dvalid held high.
        start_scan(8'd4);
        for (int i = 0; i < 4; i++) begin
            send(seq4[i]);
            chk("sign_seq_s", 32'(sign_o[0]), 32'(sgn_s[i]));
            chk("sign_seq_u", 32'(sign_o[1]), 32'(sgn_u[i]));
        end
        chk("done_latency", 32'(done_o[0]), 32'h1);
        chk("max_s", 32'(max_o[0]), 32'h7F);
        chk("idx_s", 32'(idx_o[0]), 32'h1);
        chk("max_u", 32'(max_o[1]), 32'hFF);
        chk("idx_u", 32'(idx_o[1]), 32'h3);
        chk("model_max_s", 32'(m_max[0]), 32'h7F);
        chk("model_idx_u", 32'(m_idx[1]), 32'h3);
        @(negedge clock);
        chk("done_one_cycle", 32'(done_o[0]), 32'h0);
        chk("hold_max_idle", 32'(max_o[0]), 32'h7F);

        // Ties keep the earliest index and never flag a replace.
        start_scan(8'd3);
        for (int i = 0; i < 3; i++) begin
            send(8'h05);
            chk("tie_sign", 32'(sign_o[0]), 32'h0);
        end
        chk("tie_max", 32'(max_o[1]), 32'h05);
        chk("tie_idx", 32'(idx_o[0]), 32'h0);

        // Stall between two words.
        start_scan(8'd2);
        send(8'h80);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_busy", 32'(busy_o[0]), 32'h1);
        end
        send(8'hFF);
        chk("stall_done", 32'(done_o[0]), 32'h1);
        chk("stall_max", 32'(max_o[0]), 32'hFF);
        chk("stall_idx", 32'(idx_o[0]), 32'h1);

        // Empty block, then Start pulsed during a scan.
        start_scan(8'd0);
        chk("len0_done", 32'(done_o[0]), 32'h1);
        chk("len0_max", 32'(max_o[0]), 32'h0);
        chk("len0_idx", 32'(idx_o[1]), 32'h0);
        start_scan(8'd2);
        start = 1'b1;
        length = 8'd0;
        @(negedge clock);
        start = 1'b0;
        chk("start_in_scan_busy", 32'(busy_o[0]), 32'h1);
        send(8'h03);
        send(8'h01);
        chk("start_in_scan_done", 32'(done_o[0]), 32'h1);
        chk("start_in_scan_max", 32'(max_o[0]), 32'h03);

        // Reset after 2 of 4 words.
        start_scan(8'd4);
        send(8'h11);
        send(8'h22);
        resetn = 1'b0;
        #1;
        chk("rst_mid_max", 32'(max_o[0]), 32'h0);
        chk("rst_mid_idx", 32'(idx_o[0]), 32'h0);
        chk("rst_mid_busy", 32'(busy_o[0]), 32'h0);
        chk("rst_mid_dready", 32'(dready_o[1]), 32'h0);
        chk("rst_mid_done", 32'(done_o[0]), 32'h0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        start_scan(8'd3);
        send(8'h10);
        send(8'h90);
        send(8'h20);
        chk("post_rst_max_s", 32'(max_o[0]), 32'h20);
        chk("post_rst_idx_s", 32'(idx_o[0]), 32'h2);
        chk("post_rst_max_u", 32'(max_o[1]), 32'h90);
        chk("post_rst_idx_u", 32'(idx_o[1]), 32'h1);

        // Randomized scans with stalls and stray Start pulses.
        for (int t = 0; t < 40; t++) begin
            int guard;
            start_scan(8'($urandom_range(0, 12)));
            guard = 0;
            while (m_state == 1 && guard < 400) begin
                dvalid = ($urandom_range(0, 2) != 0);
                din    = 8'($urandom);
                start  = ($urandom_range(0, 7) == 0);
                length = 8'($urandom);
                @(negedge clock);
                guard++;
            end
            dvalid = 1'b0;
            start  = 1'b0;
            chk("rand_scan_bound", 32'(guard < 400), 32'h1);
        end
        wait_idle();
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_max_scanner.md
Name: signed_max_scanner

Overview:
- Streaming signed/unsigned maximum finder for the memory-to-memory transfer datapath.
- Successor to the single-pair combinational comparator: parametrised width, selectable signedness, and sequential scan of a block of words.
- Reports the running maximum and its index, with a per-word comparison flag.
- Sits between the source-memory read port and the transfer controller.

Parameters:
- WIDTH, 8, data word width in bits.
- LEN_W, 8, width of the Length and MaxIdx fields; max block is 2^LEN_W-1 words.
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous active-low reset.
- Start  input  1  begin scan; sampled only in IDLE.
- Length  input  LEN_W  number of words to scan; sampled with Start.
- DIn  input  WIDTH  data word from memory.
- DValid  input  1  DIn valid.
- DReady  output  1  scanner accepts DIn this cycle.
- Busy  output  1  high in SCAN.
- Done  output  1  one-cycle completion pulse.
- MaxOut  output  WIDTH  largest word seen.
- MaxIdx  output  LEN_W  index (0-based) of MaxOut.
- Sign  output  1  registered; 1 when the most recent accepted word > previous max (replace event).

Behaviour:
- Reset: all outputs 0, state IDLE, word counter 0; takes effect immediately, including mid-scan. No partial result survives reset.
- State IDLE:
  - Start=1 and Length>0: latch Length, clear counter, go to SCAN next cycle.
  - Start=1 and Length=0: go to DONE; MaxOut=0, MaxIdx=0.
- State SCAN:
  - DReady=1, Busy=1.
  - A word is accepted on each cycle with DValid=1.
  - First accepted word loads MaxOut unconditionally; MaxIdx=0; Sign=0.
  - Each later accepted word, at counter value k:
    - If DIn > MaxOut (strictly, per SIGNED), MaxOut<=DIn, MaxIdx<=k, Sign<=1.
    - Otherwise MaxOut/MaxIdx hold and Sign<=0.
  - Ties keep the earlier index.
  - DValid=0 stalls the scan: no state change, and Sign holds.
  - When the accepted count reaches Length, go to DONE on the next edge.
- State DONE: lasts exactly one cycle, Done=1, DReady=0, Busy=0, then IDLE.
- Latency: Done asserts 1 cycle after the edge that accepts the last word.
- Outputs: MaxOut/MaxIdx/Sign hold their values in IDLE until the next accepted Start.
- Start while in SCAN or DONE is ignored.
- Arithmetic:
  - SIGNED=1: compare as $signed WIDTH-bit values, so 8'h7F > 8'h80 and 8'hFF > 8'h80.
  - SIGNED=0: plain unsigned compare.
- Counter: LEN_W bits, never wraps, since Length ≤ 2^LEN_W-1.

Optional Feature:
- Macro: SCANNER_MIN_TRACK_EN.
- Defined:
  - Adds outputs MinOut [WIDTH] and MinIdx [LEN_W], reset to 0.
  - They track the strict minimum under the same rules: first word loads; replace on DIn < MinOut; ties keep the earlier index; Length=0 gives 0.
- Undefined: the ports do not exist and no min logic is built.

Test Plan:
- SIGNED=1, WIDTH=8, Length=4, words 00,7F,80,FF with DValid held high:
  - Done pulses 1 cycle after the 4th word.
  - Result MaxOut=7F, MaxIdx=1.
  - Sign sequence 0,1,0,0.
- SIGNED=0, same words: MaxOut=FF, MaxIdx=3, Sign sequence 0,1,1,1.
- Ties, Length=3, words 05,05,05: MaxOut=05, MaxIdx=0, Sign always 0.
- Stall, Length=2, words 80 then FF with 3 DValid=0 cycles between them:
  - Busy stays high throughout.
  - Result MaxOut=FF, MaxIdx=1.
  - Done occurs 1 cycle after the second accept.
- Length=0 Start: Done one cycle later with MaxOut=0, MaxIdx=0; Start pulsed during SCAN has no effect.
- Reset mid-scan, Resetn low after 2 of 4 words: all outputs 0 immediately, no Done; a fresh scan then completes correctly.
